// File: rtl/regfile_sb_if.sv
// ============================================================================
//  Module   : regfile_sb_if
//  Purpose  : Read, writeback, claim and debug signals of the scoreboarded
//             register file.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface regfile_sb_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int NRD    = 2
);
    localparam int c_LANES = DATA_W / 8;
    localparam int c_NREGS = 2 ** ADDR_W;

    logic [NRD*ADDR_W-1:0]     rd_addr;
    logic [NRD*DATA_W-1:0]     rd_data;
    logic [NRD-1:0]            rd_busy;
    logic                      wr_en;
    logic [ADDR_W-1:0]         wr_addr;
    logic [c_LANES-1:0]        wr_be;
    logic [DATA_W-1:0]         wr_data;
    logic                      claim_en;
    logic [ADDR_W-1:0]         claim_addr;
    logic                      claim_ok;
    logic                      wr_stray;
    logic [c_NREGS-1:0]        busy_vec;
    logic [c_NREGS*DATA_W-1:0] dbg_regs;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_be, wr_data, claim_en, claim_addr,
        input  rd_data, rd_busy, claim_ok, wr_stray, busy_vec, dbg_regs
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_be, wr_data, claim_en, claim_addr,
        output rd_data, rd_busy, claim_ok, wr_stray, busy_vec, dbg_regs
    );
endinterface

`default_nettype wire

// File: rtl/regfile_sb.sv
// ============================================================================
//  Module   : regfile_sb
//  Purpose  : Byte-writable register file with write-to-read bypass and a
//             per-register busy scoreboard for issue-stage claims.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_sb #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 3,
    parameter int NRD     = 2,
    parameter int BYPASS  = 1,
    parameter int R0_ZERO = 0
) (
    input wire          clk,
    input wire          rst,
    regfile_sb_if.slave bus
);
    localparam int   c_LANES = DATA_W / 8;
    localparam int   c_NREGS = 2 ** ADDR_W;
    localparam logic c_BYP   = (BYPASS != 0);
    localparam logic c_R0Z   = (R0_ZERO != 0);

    logic [DATA_W-1:0]  r_regs [c_NREGS];
    logic [c_NREGS-1:0] r_busy;
    logic               r_wr_stray;

    logic               w_wr_r0;
    logic               w_claim_r0;
    logic               w_claim_ok;
    logic               w_claim_set;
    logic               w_data_we;
    logic               w_stray_next;
    logic [c_NREGS-1:0] w_busy_next;

    assign w_wr_r0      = c_R0Z && (bus.wr_addr == '0);
    assign w_claim_r0   = c_R0Z && (bus.claim_addr == '0);
    assign w_claim_ok   = bus.claim_en & (w_claim_r0 | ~r_busy[bus.claim_addr] |
                          (bus.wr_en & (bus.wr_addr == bus.claim_addr)));
    assign w_claim_set  = w_claim_ok & ~w_claim_r0;
    assign w_data_we    = bus.wr_en & ~w_wr_r0;
    assign w_stray_next = bus.wr_en & ~w_wr_r0 & ~r_busy[bus.wr_addr];

    // Set is applied after release so a same-register claim+write stays busy.
    always_comb begin
        w_busy_next = r_busy;
        if (bus.wr_en) begin
            w_busy_next[bus.wr_addr] = 1'b0;
        end
        if (w_claim_set) begin
            w_busy_next[bus.claim_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < c_NREGS; n++) begin
                r_regs[n] <= '0;
            end
            r_busy     <= '0;
            r_wr_stray <= 1'b0;
        end else begin
            if (w_data_we) begin
                for (int k = 0; k < c_LANES; k++) begin
                    if (bus.wr_be[k]) begin
                        r_regs[bus.wr_addr][k*8 +: 8] <= bus.wr_data[k*8 +: 8];
                    end
                end
            end
            r_busy     <= w_busy_next;
            r_wr_stray <= w_stray_next;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic              w_hit;
        logic [DATA_W-1:0] w_data;

        assign w_addr = bus.rd_addr[i*ADDR_W +: ADDR_W];
        assign w_hit  = c_BYP && bus.wr_en && (bus.wr_addr == w_addr);

        always_comb begin
            w_data = r_regs[w_addr];
            for (int k = 0; k < c_LANES; k++) begin
                if (w_hit && bus.wr_be[k]) begin
                    w_data[k*8 +: 8] = bus.wr_data[k*8 +: 8];
                end
            end
            if (c_R0Z && (w_addr == '0)) begin
                w_data = '0;
            end
        end

        assign bus.rd_data[i*DATA_W +: DATA_W] = w_data;
        // A pending write to this register releases it in the same cycle.
        assign bus.rd_busy[i] = r_busy[w_addr] & ~w_hit;
    end

    for (genvar n = 0; n < c_NREGS; n++) begin : g_dbg
        assign bus.dbg_regs[n*DATA_W +: DATA_W] = r_regs[n];
    end

    assign bus.claim_ok = w_claim_ok;
    assign bus.wr_stray = r_wr_stray;
    assign bus.busy_vec = r_busy;

endmodule

`default_nettype wire

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor of the CPU's 8x16 byte-writable register file.
- Generalised in data width, register count and number of read ports, with per-byte-lane write enables.
- Adds a write-to-read bypass and a per-register busy scoreboard, so the issue stage can claim a destination and stall on pending results.
- Sits between decode/issue (reads, claims) and writeback (writes, busy release).

Parameters:
- DATA_W, 16: register width in bits; must be a multiple of 8. LANES = DATA_W/8.
- ADDR_W, 3: register address width; NREGS = 2**ADDR_W.
- NRD, 2: number of independent combinational read ports.
- BYPASS, 1: 1 = a same-cycle write is forwarded to matching read ports; 0 = reads return the stored value only.
- R0_ZERO, 0: 1 = register 0 reads as zero, ignores writes and is never busy.

Ports:
- clk  in  1  the single system clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous to clk and active-high.
- rd_addr  in  NRD*ADDR_W  read addresses; port i uses bits [i*ADDR_W +: ADDR_W].
- rd_data  out  NRD*DATA_W  read data, per-port slices as for rd_addr.
- rd_busy  out  NRD  busy bit of each read port's addressed register (after bypass release).
- wr_en  in  1  writeback strobe.
- wr_addr  in  ADDR_W  writeback destination.
- wr_be  in  LANES  byte-lane enables; bit k covers data bits [8k+7:8k].
- wr_data  in  DATA_W  writeback data.
- claim_en  in  1  issue stage requests to mark claim_addr busy.
- claim_addr  in  ADDR_W  register to claim.
- claim_ok  out  1  combinational grant for the claim this cycle.
- wr_stray  out  1  registered one-cycle pulse: the previous cycle's write hit a non-busy register.
- busy_vec  out  NREGS  current scoreboard state.
- dbg_regs  out  NREGS*DATA_W  flattened contents of all registers, register n at [n*DATA_W +: DATA_W].

Behaviour:
- Reset (rst=1 at rising edge): every register cleared to 0; busy_vec=0; wr_stray=0.
  - Writes and claims presented in the same cycle as reset are discarded.
  - Reset mid-operation drops all pending claims.
- Reads are combinational with zero latency. rd_data shows the stored value, with these overrides:
  - If BYPASS=1 and wr_en=1 and wr_addr==rd_addr, each lane with wr_be[k]=1 shows wr_data for that lane; the other lanes show the stored value.
  - If R0_ZERO=1 and rd_addr==0, rd_data=0.
- Write: at the rising edge with wr_en=1, register[wr_addr] lanes with wr_be[k]=1 take wr_data; all other lanes are held.
  - wr_be=0 changes no data but still counts as a writeback for the scoreboard.
  - R0_ZERO=1 and wr_addr==0: data is not written.
- Scoreboard: one busy bit per register.
  - Release: wr_en=1 clears busy[wr_addr] at the edge.
  - Claim: claim_ok = claim_en & (!busy[claim_addr] | (wr_en & wr_addr==claim_addr)). claim_ok=1 sets busy[claim_addr] at the edge.
  - Same-address claim and write in one cycle: the set wins, so the bit ends 1 (back-to-back reuse without a bubble).
  - Claim and write to different addresses both take effect in the same cycle.
  - claim_en with claim_ok=0 has no effect; the issue stage must retry.
  - R0_ZERO=1: claim of register 0 always gets claim_ok=1 and never sets busy[0].
- rd_busy[i] = busy[rd_addr_i] & !(wr_en & wr_addr==rd_addr_i) when BYPASS=1. With BYPASS=0, rd_busy[i] = busy[rd_addr_i].
- wr_stray: registered. It is 1 in the cycle after a write with wr_en=1 whose target had busy=0 before that edge; otherwise 0. Writes to register 0 with R0_ZERO=1 never flag. This is diagnostic only; the write still occurs.
- Address ranges are exact powers of two, so no out-of-range case exists.
- dbg_regs reflects stored values only (no bypass, no R0 masking).

Test Plan:
- Reset then read: rst high 1 cycle; all 8 rd_addr values on both ports -> rd_data=0x0000, busy_vec=0, wr_stray=0.
- Byte lanes: claim r3; write r3 data 0xABCD be=11; next write r3 data 0x1234 be=01 -> r3=0xAB34; be=10 with 0xFF00 -> 0xFF34; wr_stray stays 0 only on the first write, 1 after the second and third.
- Bypass: r5=0x1111; same cycle wr_en r5 data 0x2222 be=10, rd_addr0=5 -> rd_data0=0x2211 that cycle, dbg r5=0x2211 next cycle. Repeat with BYPASS=0 -> rd_data0=0x1111.
- Scoreboard:
  - Claim r2 -> busy_vec[2]=1 next cycle; second claim r2 -> claim_ok=0, busy unchanged.
  - Write r2 and claim r2 in the same cycle -> claim_ok=1, busy[2] remains 1.
  - Write r2 alone -> busy[2]=0.
- Parallel ops: claim r4 while writing busy r6 -> busy[4]=1, busy[6]=0 after the edge; rd_busy on a port reading r6 is 0 in the write cycle.
- Reset mid-operation and R0: with busy r1 and r7, assert rst with wr_en r1 data 0xBEEF -> r1=0, busy_vec=0. With R0_ZERO=1: write r0 0xFFFF, claim r0 -> reads 0, busy[0]=0, claim_ok=1, wr_stray=0.
